// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared types and constants for the pipelined on-chip RAM.
//   mem_state_e       - controller state (idle / zero-fill in progress)
//   MAX_READ_LATENCY  - deepest supported read pipeline
//   BE_W(data_w)      - number of byte lanes for a given word width
package onchip_mem_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } mem_state_e;

    localparam int unsigned MAX_READ_LATENCY = 2;

    function automatic int unsigned BE_W(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_mem_ram.sv
// onchip_mem_ram: byte-enabled single-port RAM with registered read.
//   clk    - clock
//   clken  - enable; low freezes both the write port and the read register
//   we     - write enable (lanes selected by be)
//   addr   - word address (caller guarantees addr < DEPTH when we is high)
//   be     - byte lane enables
//   wdata  - write data
//   rdata  - registered read data (old data on read-during-write)
// Written in the plain template that block-RAM inference recognises; the
// init image is attached through the ram_init_file attribute.
module onchip_mem_ram
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 5120,
    parameter int unsigned ADDR_W    = 13,
    parameter string       INIT_FILE = ""
) (
    input  logic                       clk,
    input  logic                       clken,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [BE_W(DATA_W)-1:0]    be,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned BW = BE_W(DATA_W);

    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clken) begin
            if (we) begin
                for (int unsigned i = 0; i < BW; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/onchip_mem_pipelined.sv
// onchip_mem_pipelined: parametrised on-chip RAM behind an Avalon-MM slave
// with pipelined reads, bounds-checked addressing and a zero-fill engine.
//   clk, reset_n      - clock, asynchronous active-low reset
//   address           - word address; accesses at or above DEPTH are inert
//   byteenable        - write byte lanes
//   chipselect, read, write, writedata - Avalon command (write wins over read)
//   clken             - global enable; low freezes the whole block
//   clear_req         - pulse that starts a zero-fill from idle
//   readdata, readdatavalid - read response, READ_LATENCY enabled edges later
//   waitrequest       - high while not accepting commands
//   clear_busy        - high while the zero-fill runs
module onchip_mem_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 5120,
    parameter int unsigned ADDR_W         = 13,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter string       INIT_FILE      = "onchip_mem.hex"
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          address,
    input  logic [BE_W(DATA_W)-1:0]    byteenable,
    input  logic                       chipselect,
    input  logic                       read,
    input  logic                       write,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       clken,
    input  logic                       clear_req,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic                       waitrequest,
    output logic                       clear_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // A zero-filling block has no use for a preload image.
    localparam string RAM_INIT = CLEAR_ON_RESET ? "" : INIT_FILE;

    mem_state_e                 state;
    logic [ADDR_W-1:0]          clr_cnt;
    logic                       rst_done;

    logic                       clearing;
    logic                       in_range;
    logic                       accept;
    logic                       acc_rd;
    logic                       acc_wr;

    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_addr;
    logic [BE_W(DATA_W)-1:0]    ram_be;
    logic [DATA_W-1:0]          ram_wdata;
    logic [DATA_W-1:0]          ram_q;

    logic                       v1;
    logic                       oob1;

    always_comb begin
        clearing    = (state == S_CLEAR);
        in_range    = (32'(address) < DEPTH);
        waitrequest = ~clken | clearing | ~rst_done;
        accept      = chipselect & (read | write) & ~waitrequest;
        acc_wr      = accept & write;
        acc_rd      = accept & read & ~write;
        clear_busy  = clearing;

        // The clear engine owns the single RAM port while it runs.
        ram_we      = clearing | (acc_wr & in_range);
        ram_addr    = clearing ? clr_cnt : address;
        ram_be      = clearing ? '1 : byteenable;
        ram_wdata   = clearing ? '0 : writedata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            clr_cnt  <= '0;
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (clken) begin
                unique case (state)
                    S_IDLE: begin
                        if (clear_req) begin
                            state   <= S_CLEAR;
                            clr_cnt <= '0;
                        end
                    end
                    S_CLEAR: begin
                        if (clr_cnt == LAST_ADDR) begin
                            state   <= S_IDLE;
                            clr_cnt <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    onchip_mem_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (RAM_INIT)
    ) u_ram (
        .clk   (clk),
        .clken (clken),
        .we    (ram_we),
        .addr  (ram_addr),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // First response stage sits alongside the RAM read register; the
    // out-of-range flag travels with it so the data can be forced to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            oob1 <= 1'b0;
        end else if (clken) begin
            v1   <= acc_rd;
            oob1 <= ~in_range;
        end
    end

    // The strobe is qualified by clken so a response parked at the last
    // stage during a freeze is emitted once, in the first enabled cycle.
    if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_out_reg
        logic              out_v;
        logic [DATA_W-1:0] out_d;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_v <= 1'b0;
                out_d <= '0;
            end else if (clken) begin
                out_v <= v1;
                if (v1) begin
                    out_d <= oob1 ? '0 : ram_q;
                end
            end
        end

        assign readdatavalid = out_v & clken;
        assign readdata      = out_d;
    end else begin : g_no_out_reg
        assign readdatavalid = v1 & clken;
        assign readdata      = (v1 && !oob1) ? ram_q : '0;
    end

endmodule

// File: tb/tb_onchip_mem_pipelined.sv
module tb_onchip_mem_pipelined;

    localparam int DEPTH = 5120;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [12:0] address = '0;
    logic [3:0]  byteenable = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        clken = 1'b0;
    logic        clear_req = 1'b0;

    logic [31:0] rd_a, rd_b;
    logic        rdv_a, rdv_b, wr_a, wr_b, cb_a, cb_b;

    always #5 clk = ~clk;

    onchip_mem_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(13), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1'b0), .INIT_FILE("")
    ) u_a (
        .clk(clk), .reset_n(rst_a), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .clear_req(clear_req), .readdata(rd_a),
        .readdatavalid(rdv_a), .waitrequest(wr_a), .clear_busy(cb_a)
    );

    onchip_mem_pipelined #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(13), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) u_b (
        .clk(clk), .reset_n(rst_b), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .clear_req(clear_req), .readdata(rd_b),
        .readdatavalid(rdv_b), .waitrequest(wr_b), .clear_busy(cb_b)
    );

    // Only one instance is exercised at a time; sel picks which one.
    bit sel = 1'b0;
    wire        mrst_n    = sel ? rst_b : rst_a;
    wire [31:0] obs_rdata = sel ? rd_b : rd_a;
    wire        obs_rdv   = sel ? rdv_b : rdv_a;
    wire        obs_wr    = sel ? wr_b : wr_a;
    wire        obs_cb    = sel ? cb_b : cb_a;

    int ncmp = 0;
    int nerr = 0;
    int rdv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] d;
        bit          care;
        longint      due;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] mv[int];
    logic [3:0]  mk[int];
    bit          m_zero = 1'b0;
    bit          m_busy = 1'b0;
    int          m_clr_left = 0;
    bit          m_rst_done = 1'b0;
    longint      en_count = 0;

    task automatic m_write(input int a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] v;
        logic [3:0]  k;
        if (a >= DEPTH) return;
        if (mk.exists(a)) begin
            v = mv[a];
            k = mk[a];
        end else begin
            v = '0;
            k = m_zero ? 4'hF : 4'h0;
        end
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                v[i*8 +: 8] = d[i*8 +: 8];
                k[i] = 1'b1;
            end
        end
        mv[a] = v;
        mk[a] = k;
    endtask

    task automatic m_read(input int a);
        resp_t r;
        r.due = en_count + (sel ? 2 : 1);
        r.d = '0;
        r.care = 1'b0;
        if (a >= DEPTH) r.care = 1'b1;
        else if (mk.exists(a)) begin
            r.care = (mk[a] == 4'hF);
            r.d = mv[a];
        end else if (m_zero) r.care = 1'b1;
        rq.push_back(r);
    endtask

    initial forever begin
        @(posedge clk or negedge mrst_n);
        if (!mrst_n) begin
            rq.delete();
            m_rst_done = 1'b0;
            m_busy = sel;
            m_clr_left = sel ? DEPTH : 0;
        end else begin
            if (clken) begin
                if (rq.size() > 0 && rq[0].due == en_count) void'(rq.pop_front());
                if (m_busy) begin
                    m_clr_left--;
                    if (m_clr_left == 0) begin
                        m_busy = 1'b0;
                        m_zero = 1'b1;
                        mv.delete();
                        mk.delete();
                    end
                end else begin
                    if (m_rst_done && chipselect) begin
                        if (write) m_write(int'(address), writedata, byteenable);
                        else if (read) m_read(int'(address));
                    end
                    if (clear_req) begin
                        m_busy = 1'b1;
                        m_clr_left = DEPTH;
                    end
                end
                en_count++;
            end
            m_rst_done = 1'b1;
        end
    end

    // Per-cycle comparison of the active instance against the model.
    initial forever begin
        bit exp_rdv;
        @(negedge clk);
        check("waitrequest", 32'(obs_wr), 32'(!clken || m_busy || !m_rst_done));
        check("clear_busy", 32'(obs_cb), 32'(m_busy));
        exp_rdv = mrst_n && clken && rq.size() > 0 && rq[0].due == en_count;
        check("readdatavalid", 32'(obs_rdv), 32'(exp_rdv));
        if (obs_rdv) rdv_cnt++;
        if (exp_rdv && rq[0].care) check("readdata", obs_rdata, rq[0].d);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        read = 1'b0;
        write = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = 13'(a); writedata = d; byteenable = be;
        tick();
        idle();
    endtask

    task automatic rd_nb(input int a);
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = 13'(a);
        tick();
    endtask

    task automatic wait_clear_done(input bit b, input string tag);
        for (int i = 0; i < 6000 && (b ? cb_b : cb_a); i++) tick();
        check(tag, 32'(b ? cb_b : cb_a), 32'd0);
    endtask

    task automatic burst_with_stall();
        int c0;
        for (int i = 0; i < 8; i++) wr(i, 32'hA5000000 + 32'(i * 3), 4'hF);
        c0 = rdv_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                chipselect = 1'b1; read = 1'b1; address = 13'(i);
                clken = 1'b0;
                repeat (3) tick();
                clken = 1'b1;
            end
            rd_nb(i);
        end
        idle();
        repeat (4) tick();
        check("burst_strobes", 32'(rdv_cnt - c0), 32'd8);
    endtask

    task automatic bounds_test();
        wr(880, 32'h08800880, 4'hF);
        wr(1904, 32'h19041904, 4'hF);
        wr(5119, 32'h00000055, 4'hF);
        wr(6000, 32'hFFFFFFFF, 4'hF);
        rd_nb(5119); rd_nb(5120); rd_nb(8191); rd_nb(880); rd_nb(1904);
        idle();
        repeat (4) tick();
    endtask

    task automatic random_phase(input int n);
        int r, a;
        for (int i = 0; i < n; i++) begin
            clken = ($urandom_range(0, 9) != 0);
            chipselect = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 3);
            read = (r != 0);
            write = (r == 0 || r == 3);
            r = $urandom_range(0, 9);
            if (r < 6) a = $urandom_range(0, 15);
            else if (r < 8) a = $urandom_range(5110, 5130);
            else if (r == 8) a = $urandom_range(8180, 8191);
            else a = $urandom_range(0, 8191);
            address = 13'(a);
            byteenable = 4'($urandom_range(0, 15));
            writedata = $urandom;
            tick();
        end
        idle();
        clken = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        clken = 1'b1;
        idle();
        repeat (3) tick();
        check("reset_readdata", rd_a, 32'd0);
        check("reset_rdv", 32'(rdv_a), 32'd0);
        check("reset_waitreq", 32'(wr_a), 32'd1);

        // ---- instance A: READ_LATENCY=1, no clear on reset ----
        rst_a = 1'b1;
        check("release_waitreq", 32'(wr_a), 32'd1);
        tick();
        check("ready_waitreq", 32'(wr_a), 32'd0);
        repeat (3) tick();

        wr(5, 32'h11223344, 4'hF);
        wr(5, 32'hDEADBEEF, 4'b0101);
        rd_nb(5);
        idle();
        check("rl1_rdv", 32'(rdv_a), 32'd1);
        check("rl1_merge", rd_a, 32'h11AD33EF);
        repeat (2) tick();

        burst_with_stall();
        bounds_test();
        random_phase(400);

        wr(5, 32'hCAFEF00D, 4'hF);
        wr(6, 32'h0BADC0DE, 4'hF);
        rd_nb(5);
        address = 13'd6; clear_req = 1'b1;
        tick();
        idle();
        repeat (50) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        rd_nb(7);
        idle();
        wait_clear_done(1'b0, "clear_a_done");
        rd_nb(0); rd_nb(5); rd_nb(6); rd_nb(880); rd_nb(5119);
        for (int i = 0; i < 4; i++) rd_nb($urandom_range(0, 8191));
        idle();
        repeat (4) tick();

        // ---- instance B: READ_LATENCY=2, clear on reset ----
        rst_a = 1'b0;
        tick();
        sel = 1'b1;
        mv.delete();
        mk.delete();
        m_zero = 1'b0;
        m_busy = 1'b1;
        m_clr_left = DEPTH;
        m_rst_done = 1'b0;
        tick();
        check("b_reset_busy", 32'(cb_b), 32'd1);
        rst_b = 1'b1;
        repeat (40) tick();
        clken = 1'b0;
        repeat (5) tick();
        clken = 1'b1;
        repeat (60) tick();
        rst_b = 1'b0;
        repeat (2) tick();
        rst_b = 1'b1;
        wait_clear_done(1'b1, "clear_b_done");

        wr(5, 32'h11223344, 4'hF);
        wr(5, 32'hDEADBEEF, 4'b0101);
        rd_nb(5);
        idle();
        check("rl2_early", 32'(rdv_b), 32'd0);
        tick();
        check("rl2_rdv", 32'(rdv_b), 32'd1);
        check("rl2_merge", rd_b, 32'h11AD33EF);
        repeat (2) tick();

        burst_with_stall();
        bounds_test();
        random_phase(400);

        rd_nb(1);
        rd_nb(2);
        idle();
        rst_b = 1'b0;
        repeat (2) tick();
        rst_b = 1'b1;
        repeat (4) tick();
        wait_clear_done(1'b1, "clear_b_redo");
        rd_nb(3); rd_nb(5119); rd_nb(8000);
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
